spi_word_buffer: RTL

Parametrised SPI slave receive buffer, successor to the fixed 8-bit shift-in buffer. It oversamples SCK, CS and DI on the system clock and deserialises WIDTH-bit words in any of the four SPI modes. Completed words go into a DEPTH-entry FIFO with a valid/ready handshake, and overruns and aborted frames are flagged. It sits between the board SPI pins and the command decoder, replacing the single-word Buffer/Changed pair.

---
 rtl/spi_word_buffer_pkg.sv | 29 ++
 rtl/spi_word_fifo.sv | 63 ++++++
 rtl/spi_word_buffer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/spi_word_buffer_pkg.sv
// spi_word_buffer_pkg: shared types, reset constants and edge helpers
// for the SPI slave word buffer and its FIFO.
package spi_word_buffer_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } spi_mode_t;

    localparam logic RST_DO       = 1'b1;
    localparam logic RST_CS       = 1'b1;
    localparam logic RST_TX_READY = 1'b1;

    // Sampling happens on rising SCK when the leading edge is rising
    // (CPOL=0) and CPHA=0, or when the trailing edge is rising
    // (CPOL=1) and CPHA=1.
    function automatic logic sample_on_rise(input logic cpol,
                                            input logic cpha);
        return cpol == cpha;
    endfunction

    function automatic spi_mode_t mode_of(input logic cpol,
                                          input logic cpha);
        return spi_mode_t'({cpol, cpha});
    endfunction

endpackage

// File: rtl/spi_word_fifo.sv
// spi_word_fifo: first-word-fall-through FIFO for received SPI words.
// Ports: CLK/RST, push/push_data, pop, data (head), valid, full, level.
module spi_word_fifo
    import spi_word_buffer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       data,
    output logic                   valid,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign valid   = count != '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop & valid;
    // A pop in the same cycle frees the slot, so a full FIFO still
    // accepts the incoming word.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge CLK) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // The last popped word stays visible while empty.
    assign data  = valid ? mem[rd_ptr] : last_q;
    assign level = count;

endmodule

// File: rtl/spi_word_buffer.sv
// spi_word_buffer: oversampling SPI slave, WIDTH-bit words into a FIFO.
// Ports: CLK/RST, SCK/CS/DI/DO pins, RxData/RxValid/RxReady/Level,
// Overrun/OverrunClr, Abort, TxData/TxValid/TxReady.
// SPI_WORD_BUFFER_TX_EN defined: include the MISO transmitter.
module spi_word_buffer
    import spi_word_buffer_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit LSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SCK,
    input  logic                   CS,
    input  logic                   DI,
    output logic                   DO,
    output logic [WIDTH-1:0]       RxData,
    output logic                   RxValid,
    input  logic                   RxReady,
    output logic [$clog2(DEPTH):0] Level,
    output logic                   Overrun,
    input  logic                   OverrunClr,
    output logic                   Abort,
    input  logic [WIDTH-1:0]       TxData,
    input  logic                   TxValid,
    output logic                   TxReady
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam spi_mode_t      MODE = mode_of(CPOL, CPHA);
    localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] cs_q;
    logic [SYNC_STAGES-1:0] di_q;
    logic                   sck_d;
    logic                   cs_d;
    logic                   sck_s;
    logic                   cs_s;
    logic                   di_s;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sck_q <= {SYNC_STAGES{CPOL}};
            cs_q  <= {SYNC_STAGES{RST_CS}};
            di_q  <= '0;
            sck_d <= CPOL;
            cs_d  <= RST_CS;
        end else begin
            sck_q <= {sck_q[SYNC_STAGES-2:0], SCK};
            cs_q  <= {cs_q[SYNC_STAGES-2:0], CS};
            di_q  <= {di_q[SYNC_STAGES-2:0], DI};
            sck_d <= sck_q[SYNC_STAGES-1];
            cs_d  <= cs_q[SYNC_STAGES-1];
        end
    end

    assign sck_s = sck_q[SYNC_STAGES-1];
    assign cs_s  = cs_q[SYNC_STAGES-1];
    assign di_s  = di_q[SYNC_STAGES-1];

    logic rise;
    logic fall;
    logic sample_edge;
    logic cs_rise;

    assign rise        = sck_s & ~sck_d;
    assign fall        = ~sck_s & sck_d;
    assign sample_edge = SAMPLE_RISE ? rise : fall;
    assign cs_rise     = cs_s & ~cs_d;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic             take;
    logic             push;
    logic             pop;
    logic             full;
    logic             abort_q;
    logic             overrun_q;

    assign take    = ~cs_s & sample_edge;
    assign sr_next = LSB_FIRST ? {di_s, sr[WIDTH-1:1]}
                               : {sr[WIDTH-2:0], di_s};
    // The word is pushed straight from sr_next so the push lands at
    // the end of the detection cycle of its last bit.
    assign push    = take & (cnt == LAST);
    assign pop     = RxValid & RxReady;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt       <= '0;
            sr        <= '0;
            abort_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            abort_q   <= cs_rise & (cnt != '0);
            overrun_q <= (push & full & ~pop) |
                         (overrun_q & ~OverrunClr);
            if (cs_s) begin
                cnt <= '0;
                sr  <= '0;
            end else if (take) begin
                sr  <= sr_next;
                cnt <= push ? '0 : cnt + 1'b1;
            end
        end
    end

    assign Abort   = abort_q;
    assign Overrun = overrun_q;

    spi_word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_data (sr_next),
        .pop       (pop),
        .data      (RxData),
        .valid     (RxValid),
        .full      (full),
        .level     (Level)
    );

`ifdef SPI_WORD_BUFFER_TX_EN
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] tx_sr;
    logic             hold_full;
    logic             launch_edge;
    logic             cs_fall;
    logic             capture;
    logic             load;
    logic             shift;

    assign launch_edge = SAMPLE_RISE ? fall : rise;
    assign cs_fall     = ~cs_s & cs_d;
    assign TxReady     = ~hold_full;
    assign capture     = TxValid & ~hold_full;
    // A launch edge with the counter at zero opens a new word; with
    // CPHA=0 the first bit must already be on DO at CS fall.
    assign load  = ~cs_s & ((launch_edge & (cnt == '0)) |
                            (~CPHA & cs_fall));
    assign shift = ~cs_s & launch_edge & (cnt != '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_q    <= '0;
            hold_full <= ~RST_TX_READY;
            tx_sr     <= '1;
        end else begin
            if (capture) begin
                hold_q    <= TxData;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (cs_s)
                tx_sr <= '1;
            else if (load)
                tx_sr <= hold_full ? hold_q : '1;
            else if (shift)
                tx_sr <= LSB_FIRST ? {1'b1, tx_sr[WIDTH-1:1]}
                                   : {tx_sr[WIDTH-2:0], 1'b1};
        end
    end

    assign DO = cs_s | (LSB_FIRST ? tx_sr[0] : tx_sr[WIDTH-1]);
`else
    logic unused_tx;

    assign DO        = RST_DO;
    assign TxReady   = 1'b0;
    assign unused_tx = ^{TxData, TxValid, MODE};
`endif

endmodule
